uart_receiver: RTL

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with 2-flop rx synchronizer, start-glitch rejection and framing-error detection.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err output.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        fe_q, fe_d;
  logic        brk_q, brk_d;
  logic        rx_meta_q, rx_s_q;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
  logic        perr_q, perr_d;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      brk_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      brk_q     <= brk_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    fe_d    = 1'b0;
    brk_d   = brk_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: if (cnt_q == HALF_M1) begin
        cnt_d   = '0;
        state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL_M1) begin
        cnt_d   = '0;
        shift_d = {rx_s_q, shift_q[7:1]};
        bit_d   = (bit_q == 3'd7) ? bit_q : bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bit_q == 3'd7) state_d = PARITY;
`else
        if (bit_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt_q == FULL_M1) begin
        cnt_d   = '0;
        par_d   = rx_s_q;
        state_d = STOP;
      end
`endif
      STOP: begin
        // After a low stop bit, hold here until the line recovers so a break cannot look like a start bit.
        if (brk_q) begin
          cnt_d = '0;
          if (rx_s_q) begin
            brk_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            perr_d  = ^{shift_q, par_q};
`endif
          end else begin
            fe_d  = 1'b1;
            brk_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = fe_q;
  assign busy      = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif
endmodule
